// File: rtl/wb_sonar_array.sv
// Wishbone-controlled multi-channel ultrasonic ranger.
//
// A sweep pings every channel set in the MASK latched at sweep start, in
// ascending index order: a TRIG_CYCLES trigger pulse, a wait of up to
// TIMEOUT_CYCLES for the echo to rise, a measurement of the echo width
// (saturating at TIMEOUT_CYCLES), then a GAP_CYCLES quiet interval.
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   wb_*                  Wishbone slave, 1-cycle ack, registers at adr[7:2]
//   trig_o[N_CH]          per-channel trigger outputs (at most one high)
//   echo_i[N_CH]          per-channel asynchronous echo inputs
//   intr                  level interrupt, DONE & IE
//
// Register map:
//   0x00 CTRL   rw  [0] EN, [1] CONT, [2] IE, [8+N_CH-1:8] MASK
//   0x04 STATUS     [0] BUSY ro, [1] DONE w1c, [15:8] VALID ro, [23:16] TMO ro
//   0x08 START  wo  [0]=1 starts a sweep when EN=1 and idle
//   0x10+4*ch DIST  ro  echo width in cycles
module wb_sonar_array #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 3800000,
  parameter int unsigned GAP_CYCLES     = 6000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  input  logic            wb_we_i,
  input  logic [3:0]      wb_sel_i,
  output logic            wb_ack_o,
  output logic [N_CH-1:0] trig_o,
  input  logic [N_CH-1:0] echo_i,
  output logic            intr
);

  localparam int unsigned ChW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned MaxA   = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCyc = (MaxA > TIMEOUT_CYCLES) ? MaxA : TIMEOUT_CYCLES;
  localparam int unsigned TmrW   = $clog2(MaxCyc + 1);

  localparam logic [TmrW-1:0] TrigLast = TmrW'(TRIG_CYCLES - 1);
  localparam logic [TmrW-1:0] WaitLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [TmrW-1:0] MeasMax  = TmrW'(TIMEOUT_CYCLES);
  localparam logic [TmrW-1:0] GapLast  = TmrW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StGap} state_e;

  state_e            state_q, state_d;
  logic [ChW-1:0]    ch_q, ch_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              ack_q;
  logic              en_q, en_d, cont_q, cont_d, ie_q, ie_d;
  logic [N_CH-1:0]   mask_q, mask_d, sweep_mask_q, sweep_mask_d;
  logic              done_q, done_d, restart_q, restart_d;
  logic [N_CH-1:0]   valid_q, valid_d, tmo_q, tmo_d;
  logic [N_CH-1:0]   echo_m_q, echo_s_q, echo_p_q;
  logic [CNT_W-1:0]  dist_q [N_CH];

  logic              dist_we;
  logic [CNT_W-1:0]  dist_val;
  logic              set_done, begin_sweep, busy;
  logic              acc, wr, ctrl_wr, stat_wr, start_wr;
  logic [5:0]        reg_idx;
  logic [ChW:0]      first_ch, next_ch;
  logic              e_now, e_prev;
  logic [31:0]       rdata;
  logic              unused_bits;

  // Lowest set bit of m at index >= lo, returned as {found, index}.
  function automatic logic [ChW:0] find_from(input logic [N_CH-1:0] m, input int lo);
    logic [ChW:0] res;
    res = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) res = {1'b1, ChW'(i)};
    end
    return res;
  endfunction

  // Bus decode; the access completes on the ack cycle.
  assign reg_idx  = wb_adr_i[7:2];
  assign acc      = ack_q & wb_stb_i & wb_cyc_i;
  assign wr       = acc & wb_we_i;
  assign ctrl_wr  = wr && (reg_idx == 6'd0);
  assign stat_wr  = wr && (reg_idx == 6'd1);
  assign start_wr = wr && (reg_idx == 6'd2) && wb_dat_i[0];
  assign wb_ack_o = ack_q;

  assign busy     = (state_q != StIdle);
  assign intr     = done_q & ie_q;
  assign e_now    = echo_s_q[ch_q];
  assign e_prev   = echo_p_q[ch_q];
  assign first_ch = find_from(mask_q, 0);
  assign next_ch  = find_from(sweep_mask_q, int'(ch_q) + 1);

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    en_d   = en_q;
    cont_d = cont_q;
    ie_d   = ie_q;
    mask_d = mask_q;
    if (ctrl_wr) begin
      en_d   = wb_dat_i[0];
      cont_d = wb_dat_i[1];
      ie_d   = wb_dat_i[2];
      mask_d = wb_dat_i[8 +: N_CH];
    end
  end

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tmr_d        = tmr_q;
    sweep_mask_d = sweep_mask_q;
    valid_d      = valid_q;
    tmo_d        = tmo_q;
    done_d       = done_q;
    restart_d    = restart_q;
    dist_we      = 1'b0;
    dist_val     = '0;
    set_done     = 1'b0;
    begin_sweep  = 1'b0;

    unique case (state_q)
      StIdle: begin
        restart_d = 1'b0;
        if (en_d && (start_wr || (restart_q && cont_q))) begin_sweep = 1'b1;
      end
      StTrig: begin
        if (tmr_q == TrigLast) begin
          state_d = StWaitRise;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StWaitRise: begin
        // Edge, not level: an echo already high on entry is not a rise.
        if (e_now && !e_prev) begin
          state_d = StMeasure;
          tmr_d   = TmrW'(1);
        end else if (tmr_q == WaitLast) begin
          tmo_d[ch_q]   = 1'b1;
          valid_d[ch_q] = 1'b0;
          dist_we       = 1'b1;
          state_d       = StGap;
          tmr_d         = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StMeasure: begin
        if (!e_now) begin
          valid_d[ch_q] = 1'b1;
          dist_we       = 1'b1;
          dist_val      = CNT_W'(tmr_q);
          state_d       = StGap;
          tmr_d         = '0;
        end else if (tmr_q == MeasMax) begin
          tmo_d[ch_q]   = 1'b1;
          valid_d[ch_q] = 1'b0;
          dist_we       = 1'b1;
          dist_val      = CNT_W'(MeasMax);
          state_d       = StGap;
          tmr_d         = '0;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      StGap: begin
        if (tmr_q == GapLast) begin
          tmr_d = '0;
          if (next_ch[ChW]) begin
            state_d = StTrig;
            ch_d    = next_ch[ChW-1:0];
          end else begin
            state_d   = StIdle;
            set_done  = 1'b1;
            restart_d = en_q && cont_q;
          end
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (begin_sweep) begin
      sweep_mask_d = mask_q;
      valid_d      = valid_q & ~mask_q;
      tmo_d        = tmo_q & ~mask_q;
      tmr_d        = '0;
      if (first_ch[ChW]) begin
        state_d = StTrig;
        ch_d    = first_ch[ChW-1:0];
      end else begin
        set_done = 1'b1;
      end
    end

    // EN cleared mid-sweep: abandon the sweep, keep results, leave DONE alone.
    if (busy && !en_d) begin
      state_d   = StIdle;
      tmr_d     = '0;
      restart_d = 1'b0;
      set_done  = 1'b0;
    end

    if (stat_wr && wb_dat_i[1]) done_d = 1'b0;
    if (set_done) done_d = 1'b1;
  end

  always_comb begin
    trig_o = '0;
    if (state_q == StTrig) trig_o[ch_q] = 1'b1;
  end

  always_comb begin
    rdata = '0;
    if (reg_idx == 6'd0) begin
      rdata[0]          = en_q;
      rdata[1]          = cont_q;
      rdata[2]          = ie_q;
      rdata[8 +: N_CH]  = mask_q;
    end else if (reg_idx == 6'd1) begin
      rdata[0]          = busy;
      rdata[1]          = done_q;
      rdata[8 +: N_CH]  = valid_q;
      rdata[16 +: N_CH] = tmo_q;
    end else if (reg_idx >= 6'd4 && reg_idx < 6'(4 + N_CH)) begin
      rdata = 32'(dist_q[ChW'(reg_idx - 6'd4)]);
    end
  end

  assign wb_dat_o = (ack_q && !wb_we_i) ? rdata : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      ch_q         <= '0;
      tmr_q        <= '0;
      ack_q        <= 1'b0;
      en_q         <= 1'b0;
      cont_q       <= 1'b0;
      ie_q         <= 1'b0;
      mask_q       <= '0;
      sweep_mask_q <= '0;
      done_q       <= 1'b0;
      restart_q    <= 1'b0;
      valid_q      <= '0;
      tmo_q        <= '0;
      echo_m_q     <= '0;
      echo_s_q     <= '0;
      echo_p_q     <= '0;
      for (int i = 0; i < int'(N_CH); i++) dist_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tmr_q        <= tmr_d;
      ack_q        <= wb_stb_i & wb_cyc_i & ~ack_q;
      en_q         <= en_d;
      cont_q       <= cont_d;
      ie_q         <= ie_d;
      mask_q       <= mask_d;
      sweep_mask_q <= sweep_mask_d;
      done_q       <= done_d;
      restart_q    <= restart_d;
      valid_q      <= valid_d;
      tmo_q        <= tmo_d;
      echo_m_q     <= echo_i;
      echo_s_q     <= echo_m_q;
      echo_p_q     <= echo_s_q;
      if (dist_we) dist_q[ch_q] <= dist_val;
    end
  end

endmodule

// File: doc/wb_sonar_array.md
WB_SONAR_ARRAY -- requirements
Module: wb_sonar_array

Interface
REQ-001 N_CH, 2, number of trigger/echo channels (1..8).
REQ-002 TRIG_CYCLES, 1000, trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-003 TIMEOUT_CYCLES, 3800000, maximum echo wait and echo width in clk cycles.
REQ-004 GAP_CYCLES, 6000000, quiet interval after each channel ping before the next one.
REQ-005 CNT_W, 24, echo counter width; must be at least clog2(TIMEOUT_CYCLES+1).
REQ-006 clk  in  1  system clock; the single clock of the block.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 wb_adr_i  in  32  Wishbone address; bits [7:2] decode the register.
REQ-009 wb_dat_i  in  32  Wishbone write data.
REQ-010 wb_dat_o  out  32  Wishbone read data.
REQ-011 wb_stb_i / wb_cyc_i / wb_we_i  in  1 each  Wishbone strobe, cycle and write enable.
REQ-012 wb_sel_i  in  4  byte selects; ignored, all accesses are full 32-bit.
REQ-013 wb_ack_o  out  1  Wishbone acknowledge.
REQ-014 trig_o  out  N_CH  per-channel trigger outputs.
REQ-015 echo_i  in  N_CH  per-channel asynchronous echo inputs.
REQ-016 intr  out  1  active-high interrupt, level = DONE & IE.

Function
REQ-017 Bus: wb_ack_o SHALL pulse high for exactly 1 cycle, 1 cycle after stb&cyc&!ack; write side effects and read data take effect on the ack cycle.
REQ-018 Register map: 0x00 CTRL (rw): bit0 EN, bit1 CONT, bit2 IE, bits[8+N_CH-1:8] MASK.
REQ-019 0x04 STATUS: bit0 BUSY (ro), bit1 DONE (w1c), [15:8] VALID per channel (ro), [23:16] TMO per channel (ro).
REQ-020 0x08 START (wo): write with bit0=1 SHALL start a sweep only if EN=1 and BUSY=0; otherwise it is ignored.
REQ-021 0x10+4*ch DIST[ch] (ro): echo width in cycles, zero-extended; unmapped or unimplemented addresses SHALL read 0 and ignore writes.
REQ-022 Each echo_i bit SHALL pass a 2-flop synchroniser; all edge detection uses synchronised values.
REQ-023 FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP. Sweep visits MASK channels in ascending index order.
REQ-024 IDLE->TRIG on an accepted START (or CONT restart); at sweep start, VALID and TMO for masked channels clear; BUSY=1.
REQ-025 TRIG: trig_o[ch]=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE; only one trig_o bit is ever high.
REQ-026 WAIT_RISE: on a synchronised 0->1 echo edge go to MEASURE with counter=1; an echo already high at entry SHALL NOT count until it goes low and rises again.
REQ-027 WAIT_RISE timeout: after TIMEOUT_CYCLES with no edge, set TMO[ch], DIST[ch]=0, VALID[ch]=0, go GAP.
REQ-028 MEASURE: count cycles with echo high; on falling edge DIST[ch]=count, VALID[ch]=1, go GAP.
REQ-029 MEASURE overflow: when count reaches TIMEOUT_CYCLES, saturate DIST[ch]=TIMEOUT_CYCLES, set TMO[ch], VALID[ch]=0, go GAP.
REQ-030 GAP: wait GAP_CYCLES, then TRIG on the next masked channel; after the last, set DONE, clear BUSY, go IDLE.
REQ-031 If CONT=1 and EN=1 at sweep completion, a new sweep SHALL start on the next cycle (DONE still set).
REQ-032 START with MASK=0 SHALL set DONE one cycle later without pinging any channel.
REQ-033 Clearing EN mid-sweep SHALL drive trig_o=0 and return to IDLE on the next cycle; BUSY clears, DONE unchanged, partial results kept.
REQ-034 DONE set by sweep completion in the same cycle as a w1c clear: set wins.
REQ-035 CTRL MASK written mid-sweep SHALL take effect at the next sweep only (latched at sweep start).

Reset
REQ-036 While reset=0: trig_o=0, wb_ack_o=0, wb_dat_o=0, intr=0, all registers and DIST=0, synchronisers 0, FSM=IDLE; reset asserted mid-sweep forces this immediately, asynchronously.

Verification (N_CH=4, TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, GAP_CYCLES=50, CNT_W=16)
REQ-037 CTRL=0x0305, START; echo0 high 200 cycles after trigger -> trig_o[0] high 10 cycles, DIST[0]=200 (+-1), VALID[0]=1, then channel 1 triggered after gap.
REQ-038 Channel 1 echo never rises -> TMO[1]=1, DIST[1]=0; channel 1 echo high 1500 cycles -> DIST[1]=1000, TMO[1]=1.
REQ-039 Sweep MASK=0x5 completes -> DONE=1, intr=1; write STATUS=0x2 -> intr=0 on the next cycle.
REQ-040 CONT=1 -> second sweep starts 1 cycle after DONE; clear EN mid-TRIG -> trig_o=0 and BUSY=0 by the next cycle.
REQ-041 START with MASK=0 -> DONE=1 after 1 cycle, no trig_o activity; START while BUSY -> ignored, sequence unchanged.
REQ-042 Assert reset during MEASURE -> all outputs 0 immediately; read DIST[0] after release -> 0.
